pe_acc_drain: RTL and testbench
===============================

PE_ACC_DRAIN -- requirements
Module: pe_acc_drain

Interface
REQ-001 SHALL have parameter OC_W, default 16, accumulator/sum width (matches adder output width).
REQ-002 SHALL have parameter CHAIN_LEN, default 4, number of shifts that fully drain one column's shadow chain (>=1).
REQ-003 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_sum  input  OC_W  adder sum output (next accumulator value).
REQ-006 SHALL have port o_acc  output  OC_W  current accumulator, fed back to the adder second operand.
REQ-007 SHALL have port i_en  input  1  compute enable; low = stall accumulator.
REQ-008 SHALL have port i_cswitch  input  1  context switch: last MAC of current output this cycle.
REQ-009 SHALL have port i_shift  input  1  drain-chain shift enable.
REQ-010 SHALL have port i_scan_in  input  OC_W  shadow value from upstream PE in chain.
REQ-011 SHALL have port o_scan_out  output  OC_W  shadow register value to downstream PE.
REQ-012 SHALL have port o_busy  output  1  shadow holds undrained result (state != EMPTY).
REQ-013 SHALL have port o_err  output  1  sticky overrun/collision flag.

Function
REQ-014 SHALL drive o_acc and o_scan_out directly from registers (no combinational path from inputs).
REQ-015 SHALL, when i_en=1 and i_cswitch=0, load acc <= i_sum (1-cycle feedback loop with adder).
REQ-016 SHALL, when i_en=1 and i_cswitch=1, load shadow <= i_sum, acc <= 0, state <= FULL, count <= 0.
REQ-017 SHALL, when i_en=0, hold acc and ignore i_cswitch.
REQ-018 SHALL, when i_shift=1 and no accepted cswitch, load shadow <= i_scan_in regardless of state or i_en.
REQ-019 SHALL implement states EMPTY, FULL, DRAINING: shift in FULL -> DRAINING, count=1; shift in DRAINING increments count; shift with count=CHAIN_LEN-1 -> EMPTY, count=0; shift in EMPTY keeps EMPTY, count unchanged.
REQ-020 SHALL, for CHAIN_LEN=1, go FULL -> EMPTY on first shift.
REQ-021 SHALL, on accepted cswitch while state != EMPTY, still overwrite shadow and set o_err (overrun).
REQ-022 SHALL, on accepted cswitch and i_shift same cycle, give cswitch priority (shadow <= i_sum, count not advanced) and set o_err.
REQ-023 SHALL treat all arithmetic as OC_W-bit two's complement with no saturation; acc wraps naturally.
REQ-024 SHALL hold o_err at 1 until reset.

Reset
REQ-025 SHALL, when i_rstn=0 at a rising edge, set acc=0, shadow=0, state=EMPTY, count=0, o_err=0, overriding all other inputs.
REQ-026 SHALL after reset present o_acc=0, o_scan_out=0, o_busy=0, o_err=0.
REQ-027 SHALL abort any drain in progress on reset mid-operation, with no partial result retained.

Structure
REQ-028 SHALL take the state enum type (EMPTY/FULL/DRAINING) from the shared systolic-array package.
REQ-029 SHALL size count as $clog2(CHAIN_LEN+1) bits, declared locally.
REQ-030 SHALL be a single flat module with no sub-modules; one per PE, downstream of the adder.

Verification
REQ-031 SHALL cover: i_en=1, i_sum driven as o_acc+3 for 4 cycles from reset -> o_acc = 3,6,9,12.
REQ-032 SHALL cover: acc=12, i_sum=15, i_cswitch=1 -> next cycle o_scan_out=15, o_acc=0, o_busy=1.
REQ-033 SHALL cover: FULL, 4 shifts with i_scan_in=0x00A1..0x00A4 -> o_scan_out tracks each, o_busy drops after 4th, o_err=0.
REQ-034 SHALL cover: cswitch after only 2 shifts (DRAINING) -> o_err=1, shadow=i_sum, sticky through later activity.
REQ-035 SHALL cover: cswitch and shift same cycle from EMPTY -> shadow=i_sum, o_err=1; i_en=0 with cswitch=1 -> no change.
REQ-036 SHALL cover: i_rstn=0 in DRAINING with acc=0x7FFF -> next cycle all outputs 0, state EMPTY; separately acc=0x7FFF, i_sum=0x8000 loads wrapped value.

Source files
------------

// File: rtl/pe_acc_drain_pkg.sv
// Shared systolic-array types: drain state of a PE's shadow register.
package pe_acc_drain_pkg;

    // EMPTY    : shadow holds nothing that still needs draining
    // FULL     : shadow just captured a finished output, no shifts yet
    // DRAINING : shadow chain is partway through being shifted out
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        DRAINING = 2'd2
    } drain_state_e;

endpackage : pe_acc_drain_pkg

// File: rtl/pe_acc_drain.sv
// Per-PE accumulator with a shadow register that is drained through a scan chain.
// The accumulator closes a one-cycle loop with the external adder. On a context
// switch the finished sum is parked in the shadow register so compute can restart
// at zero while the previous result shifts out downstream.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// EMPTY    | shadow drained (or never loaded); shifting only passes data
// FULL     | shadow holds a fresh result, no shifts taken yet
// DRAINING | count shifts taken; returns to EMPTY after CHAIN_LEN shifts
module pe_acc_drain
    import pe_acc_drain_pkg::*;
#(
    parameter int OC_W      = 16,
    parameter int CHAIN_LEN = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [OC_W-1:0] i_sum,
    output logic [OC_W-1:0] o_acc,
    input  logic            i_en,
    input  logic            i_cswitch,
    input  logic            i_shift,
    input  logic [OC_W-1:0] i_scan_in,
    output logic [OC_W-1:0] o_scan_out,
    output logic            o_busy,
    output logic            o_err
);

    localparam int               CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               ONE_DEEP  = (CHAIN_LEN == 1);

    logic [OC_W-1:0]  acc_q,    acc_d;
    logic [OC_W-1:0]  shadow_q, shadow_d;
    drain_state_e     state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             err_q,    err_d;
    logic             cs_take;

    // Next-state: an accepted context switch always wins over a shift.
    always_comb begin
        acc_d    = acc_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        cs_take  = i_en & i_cswitch;

        if (i_en) begin
            if (i_cswitch) begin
                shadow_d = i_sum;
                acc_d    = '0;
                state_d  = FULL;
                count_d  = '0;
                // Overwriting an undrained result, or dropping a same-cycle shift,
                // loses data somewhere in the chain.
                if ((state_q != EMPTY) || i_shift) begin
                    err_d = 1'b1;
                end
            end else begin
                acc_d = i_sum;
            end
        end

        if (!cs_take && i_shift) begin
            shadow_d = i_scan_in;
            case (state_q)
                FULL: begin
                    if (ONE_DEEP) begin
                        state_d = EMPTY;
                        count_d = '0;
                    end else begin
                        state_d = DRAINING;
                        count_d = CNT_ONE;
                    end
                end
                DRAINING: begin
                    if (count_q == CNT_LAST) begin
                        state_d = EMPTY;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous active-low reset overriding everything.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            acc_q    <= '0;
            shadow_q <= '0;
            state_q  <= EMPTY;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign o_acc      = acc_q;
    assign o_scan_out = shadow_q;
    assign o_busy     = (state_q != EMPTY);
    assign o_err      = err_q;

endmodule : pe_acc_drain

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain with hand-computed expectations.
module tb_pe_acc_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sum;
    logic [15:0] acc;
    logic        en;
    logic        cswitch;
    logic        shift;
    logic [15:0] scan_in;
    logic [15:0] scan_out;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    pe_acc_drain #(.OC_W(16), .CHAIN_LEN(4)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_sum      (sum),
        .o_acc      (acc),
        .i_en       (en),
        .i_cswitch  (cswitch),
        .i_shift    (shift),
        .i_scan_in  (scan_in),
        .o_scan_out (scan_out),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rstn = 1'b1; en = 1'b0; cswitch = 1'b0; shift = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_acc, input logic [15:0] e_scan,
                           input logic e_busy, input logic e_err);
        chk({tag, "_acc"},  acc,             e_acc);
        chk({tag, "_scan"}, scan_out,        e_scan);
        chk({tag, "_busy"}, {15'd0, busy},   {15'd0, e_busy});
        chk({tag, "_err"},  {15'd0, err},    {15'd0, e_err});
    endtask

    initial begin
        logic [15:0] exp_acc;
        sum = 16'h0; scan_in = 16'h0;
        idle();
        // Inputs driven at reset time are ignored: reset overrides.
        en = 1'b1; cswitch = 1'b1; shift = 1'b1; sum = 16'h5555; scan_in = 16'hAAAA;
        rstn = 1'b0;
        cyc();
        chk_all("reset", 16'h0, 16'h0, 1'b0, 1'b0);
        idle();

        // Accumulate +3 four times.
        exp_acc = 16'h0;
        for (int i = 0; i < 4; i++) begin
            en  = 1'b1;
            sum = exp_acc + 16'd3;
            cyc();
            exp_acc = exp_acc + 16'd3;
            chk($sformatf("accum%0d", i), acc, exp_acc);
        end
        chk("accum_final", acc, 16'd12);

        // Context switch parks 15 in the shadow.
        sum = 16'd15; cswitch = 1'b1;
        cyc();
        chk_all("cswitch", 16'h0, 16'd15, 1'b1, 1'b0);
        idle();

        // Full drain: four shifts.
        for (int i = 0; i < 4; i++) begin
            shift   = 1'b1;
            scan_in = 16'h00A1 + 16'(i);
            cyc();
            chk($sformatf("drain_scan%0d", i), scan_out, 16'h00A1 + 16'(i));
            chk($sformatf("drain_busy%0d", i), {15'd0, busy}, (i < 3) ? 16'd1 : 16'd0);
        end
        chk("drain_err", {15'd0, err}, 16'd0);
        // Extra shift in EMPTY only passes data.
        scan_in = 16'h00A5;
        cyc();
        chk_all("empty_shift", 16'h0, 16'h00A5, 1'b0, 1'b0);
        idle();

        // Overrun: cswitch while DRAINING.
        en = 1'b1; cswitch = 1'b1; sum = 16'h0050;
        cyc();
        chk_all("load2", 16'h0, 16'h0050, 1'b1, 1'b0);
        idle();
        shift = 1'b1; scan_in = 16'h00B1; cyc();
        scan_in = 16'h00B2; cyc();
        chk_all("drain2", 16'h0, 16'h00B2, 1'b1, 1'b0);
        idle();
        en = 1'b1; cswitch = 1'b1; sum = 16'h0077;
        cyc();
        chk_all("overrun", 16'h0, 16'h0077, 1'b1, 1'b1);
        idle();
        shift = 1'b1; scan_in = 16'h00C1; cyc(); cyc(); cyc(); cyc(); cyc();
        idle();
        en = 1'b1; sum = 16'h0009; cyc();
        idle();
        chk_all("sticky", 16'h0009, 16'h00C1, 1'b0, 1'b1);

        // Collision from EMPTY: cswitch wins over same-cycle shift.
        do_reset();
        chk_all("reset2", 16'h0, 16'h0, 1'b0, 1'b0);
        en = 1'b1; cswitch = 1'b1; shift = 1'b1; sum = 16'h0123; scan_in = 16'h0999;
        cyc();
        chk_all("collide", 16'h0, 16'h0123, 1'b1, 1'b1);
        idle();
        // Stalled cswitch is ignored entirely.
        cswitch = 1'b1; sum = 16'h0555;
        cyc();
        chk_all("stall_cs", 16'h0, 16'h0123, 1'b1, 1'b1);
        idle();
        // Count was not advanced by the collision: still needs four shifts.
        shift = 1'b1; scan_in = 16'h0D00;
        cyc(); cyc(); cyc();
        chk("collide_busy3", {15'd0, busy}, 16'd1);
        cyc();
        chk("collide_busy4", {15'd0, busy}, 16'd0);
        idle();

        // Reset mid-drain with acc=0x7FFF.
        do_reset();
        en = 1'b1; cswitch = 1'b1; sum = 16'h1111;
        cyc();
        cswitch = 1'b0; shift = 1'b1; sum = 16'h7FFF; scan_in = 16'h0E01;
        cyc();
        chk_all("pre_rst", 16'h7FFF, 16'h0E01, 1'b1, 1'b0);
        en = 1'b1; shift = 1'b1; rstn = 1'b0;
        cyc();
        chk_all("mid_rst", 16'h0, 16'h0, 1'b0, 1'b0);
        idle();
        shift = 1'b1; scan_in = 16'h0E02;
        cyc();
        chk_all("post_rst_shift", 16'h0, 16'h0E02, 1'b0, 1'b0);
        idle();

        // Wrap: 0x7FFF then adder output 0x8000.
        en = 1'b1; sum = 16'h7FFF; cyc();
        chk("wrap_pre", acc, 16'h7FFF);
        sum = 16'h8000; cyc();
        chk("wrap", acc, 16'h8000);
        idle();
        cyc();
        chk("wrap_hold", acc, 16'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pe_acc_drain
